// File: rtl/dest_data_mux_pkg.sv
// Shared types and constants for the destination data multiplexer and its arbiter.
package dest_data_mux_pkg;

    localparam int unsigned AXI_DATA_BITS = 64;
    localparam int unsigned BLEN_BITS     = 4;
    localparam int unsigned PID_BITS      = 6;
    localparam int unsigned DEST_BITS     = 4;

    localparam logic DEST_MUX_ERR_RST = 1'b0;

    // Sequence entry produced by the arbiter, one per granted request
    typedef struct packed {
        logic [PID_BITS-1:0]  pid;
        logic [BLEN_BITS-1:0] len;
        logic [DEST_BITS-1:0] dest;
    } mux_user_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } mux_state_t;

    function automatic int unsigned sel_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dest_data_mux_beat_cnt.sv
// Loadable beat down-counter; flags the last beat of a packet (count zero).
module dest_beat_cnt
    import dest_data_mux_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [BLEN_BITS-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_cnt_zero
);

    logic [BLEN_BITS-1:0] r_cnt;

    // Load wins over decrement; the count saturates at zero rather than wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - BLEN_BITS'(1);
        end
    end

    assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/dest_data_mux.sv
// Routes len+1 beats per sequence entry from the selected source stream and regenerates tlast.
// Optional feature: define DEST_MUX_PID_TUSER_EN to add m_axis_tid carrying the entry pid.
module dest_data_mux
    import dest_data_mux_pkg::*;
#(
    parameter int unsigned DATA_BITS = AXI_DATA_BITS,
    parameter int unsigned N_DESTS   = 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,

    input  logic                           mux_valid,
    output logic                           mux_ready,
    input  mux_user_t                      mux_data,

    input  logic [N_DESTS-1:0]             s_axis_tvalid,
    output logic [N_DESTS-1:0]             s_axis_tready,
    input  logic [N_DESTS*DATA_BITS-1:0]   s_axis_tdata,
    input  logic [N_DESTS*DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic [N_DESTS-1:0]             s_axis_tlast,

    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_BITS-1:0]           m_axis_tdata,
    output logic [DATA_BITS/8-1:0]         m_axis_tkeep,
    output logic                           m_axis_tlast,

    output logic                           err_dest
`ifdef DEST_MUX_PID_TUSER_EN
    ,
    output logic [PID_BITS-1:0]            m_axis_tid
`endif
);

    localparam int unsigned KEEP_BITS = DATA_BITS / 8;
    localparam int unsigned SEL_BITS  = sel_bits(N_DESTS);

    mux_state_t           r_state;
    mux_state_t           w_state_nxt;
    logic [SEL_BITS-1:0]  r_sel;
    logic                 r_err_dest;

    logic                 w_cnt_zero;
    logic                 w_active;
    logic                 w_dest_ok;
    logic                 w_beat;
    logic                 w_load;
    logic                 w_dec;
    logic                 w_err_set;
    logic                 w_src_valid;
    logic [DATA_BITS-1:0] w_src_data;
    logic [KEEP_BITS-1:0] w_src_keep;
    logic                 w_unused_tlast;

    assign w_active       = (r_state == ST_ACTIVE);
    assign w_dest_ok      = (32'(mux_data.dest) < N_DESTS);
    assign w_unused_tlast = ^s_axis_tlast;

    // Select the currently routed source
    always_comb begin
        w_src_valid = 1'b0;
        w_src_data  = '0;
        w_src_keep  = '0;
        for (int unsigned i = 0; i < N_DESTS; i++) begin
            if (r_sel == SEL_BITS'(i)) begin
                w_src_valid = s_axis_tvalid[i];
                w_src_data  = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
                w_src_keep  = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
            end
        end
    end

    // Next state and entry pop; the last-beat handshake doubles as the next pop slot
    always_comb begin
        w_state_nxt = r_state;
        mux_ready   = 1'b0;
        w_beat      = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mux_ready = aresetn;
                if (mux_valid && aresetn) begin
                    if (w_dest_ok) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_err_set   = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                w_beat = w_src_valid && m_axis_tready;
                if (w_beat) begin
                    if (w_cnt_zero) begin
                        mux_ready   = 1'b1;
                        w_state_nxt = ST_IDLE;
                        if (mux_valid) begin
                            if (w_dest_ok) begin
                                w_load      = 1'b1;
                                w_state_nxt = ST_ACTIVE;
                            end else begin
                                w_err_set   = 1'b1;
                            end
                        end
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sel      <= '0;
            r_err_dest <= DEST_MUX_ERR_RST;
        end else begin
            if (w_load) begin
                r_sel <= SEL_BITS'(mux_data.dest);
            end
            if (w_err_set) begin
                r_err_dest <= 1'b1;
            end
        end
    end

    dest_beat_cnt u_beat_cnt (
        .i_clk      (aclk),
        .i_rst_n    (aresetn),
        .i_load     (w_load),
        .i_load_val (mux_data.len),
        .i_dec      (w_dec),
        .o_cnt_zero (w_cnt_zero)
    );

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned i = 0; i < N_DESTS; i++) begin
            s_axis_tready[i] = w_active && (r_sel == SEL_BITS'(i)) && m_axis_tready;
        end
    end

    assign m_axis_tvalid = w_active && w_src_valid;
    assign m_axis_tdata  = w_src_data;
    assign m_axis_tkeep  = w_src_keep;
    assign m_axis_tlast  = w_active && w_cnt_zero;
    assign err_dest      = r_err_dest;

`ifdef DEST_MUX_PID_TUSER_EN
    logic [PID_BITS-1:0] r_pid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pid <= '0;
        end else if (w_load) begin
            r_pid <= mux_data.pid;
        end
    end

    assign m_axis_tid = r_pid;
`else
    logic w_unused_pid;
    assign w_unused_pid = ^mux_data.pid;
`endif

endmodule

// File: tb/tb_dest_data_mux.sv
// Bench for dest_data_mux: queue-based beat model checked every cycle, directed cases, random traffic.
`timescale 1ns/1ps
module tb_dest_data_mux;
    import dest_data_mux_pkg::*;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int ND = 4;

    logic                 aclk;
    logic                 aresetn;
    logic                 mux_valid;
    logic                 mux_ready;
    mux_user_t            mux_data;
    logic [ND-1:0]        s_axis_tvalid;
    logic [ND-1:0]        s_axis_tready;
    logic [ND*DW-1:0]     s_axis_tdata;
    logic [ND*KW-1:0]     s_axis_tkeep;
    logic [ND-1:0]        s_axis_tlast;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [DW-1:0]        m_axis_tdata;
    logic [KW-1:0]        m_axis_tkeep;
    logic                 m_axis_tlast;
    logic                 err_dest;
`ifdef DEST_MUX_PID_TUSER_EN
    logic [PID_BITS-1:0]  m_axis_tid;
`endif

    dest_data_mux #(.DATA_BITS(DW), .N_DESTS(ND)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mux_valid     (mux_valid),
        .mux_ready     (mux_ready),
        .mux_data      (mux_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
`ifdef DEST_MUX_PID_TUSER_EN
        .m_axis_tid    (m_axis_tid),
`endif
        .err_dest      (err_dest)
    );

    typedef struct {
        int                  dest;
        logic [DW-1:0]       data;
        logic [KW-1:0]       keep;
        logic                last;
        logic [PID_BITS-1:0] pid;
    } beat_t;

    beat_t          bq[$];
    mux_user_t      ent_q[$];
    logic [DW-1:0]  cap_data[$];
    logic           cap_last[$];
    longint         cap_cyc[$];
    int unsigned    src_seq[ND];
    int unsigned    exp_seq[ND];
    logic           m_err;
    logic           e_mr;
    beat_t          f;
    logic           hs_mux;
    logic [ND-1:0]  hs_src;
    logic [ND-1:0]  tr_seen;
    int             p_src;
    int             p_rdy;
    longint         cyc;
    int             n_cmp;
    int             n_bad;

    function automatic logic [DW-1:0] src_word(input int s, input int unsigned q);
        return {8'(s), 8'h5A, 16'(q)};
    endfunction

    function automatic logic [KW-1:0] src_keep(input int s, input int unsigned q);
        return 4'(q + 32'(s));
    endfunction

    function automatic mux_user_t mk(input int d, input int l, input int p);
        mux_user_t e;
        e.dest = DEST_BITS'(d);
        e.len  = BLEN_BITS'(l);
        e.pid  = PID_BITS'(p);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expand one accepted entry into the beats it must produce
    task automatic accept(input mux_user_t e);
        int    d;
        beat_t b;
        d = int'(e.dest);
        if (d < ND) begin
            for (int k = 0; k <= int'(e.len); k++) begin
                b.dest = d;
                b.data = src_word(d, exp_seq[d]);
                b.keep = src_keep(d, exp_seq[d]);
                b.last = (k == int'(e.len));
                b.pid  = e.pid;
                bq.push_back(b);
                exp_seq[d]++;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Compare process: outputs for the upcoming edge are checked mid-cycle
    always @(negedge aclk) begin
        cyc++;
        hs_mux = 1'b0;
        hs_src = '0;
        if (!aresetn) begin
            bq.delete();
            m_err = 1'b0;
            for (int i = 0; i < ND; i++) exp_seq[i] = src_seq[i];
        end else begin
            tr_seen |= s_axis_tready;
            if (bq.size() == 0) begin
                chk("m_tvalid_idle", 64'(m_axis_tvalid), 64'(0));
                chk("s_tready_idle", 64'(s_axis_tready), 64'(0));
                e_mr = 1'b1;
            end else begin
                f = bq[0];
                chk("m_tvalid", 64'(m_axis_tvalid), 64'(s_axis_tvalid[f.dest]));
                chk("s_tready", 64'(s_axis_tready), m_axis_tready ? (64'(1) << f.dest) : 64'(0));
                if (m_axis_tvalid) begin
                    chk("m_tdata", 64'(m_axis_tdata), 64'(f.data));
                    chk("m_tkeep", 64'(m_axis_tkeep), 64'(f.keep));
                    chk("m_tlast", 64'(m_axis_tlast), 64'(f.last));
`ifdef DEST_MUX_PID_TUSER_EN
                    chk("m_tid", 64'(m_axis_tid), 64'(f.pid));
`endif
                end
                e_mr = m_axis_tvalid && m_axis_tready && f.last;
            end
            chk("mux_ready", 64'(mux_ready), 64'(e_mr));
            chk("err_dest", 64'(err_dest), 64'(m_err));
            if (bq.size() != 0 && m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                cap_cyc.push_back(cyc);
                void'(bq.pop_front());
            end
            hs_src = s_axis_tvalid & s_axis_tready;
            if (mux_valid && mux_ready) begin
                hs_mux = 1'b1;
                accept(mux_data);
            end
        end
    end

    // Drivers: AXI-compliant sources, entry feeder, random sink ready
    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < ND; i++) begin
            if (hs_src[i]) src_seq[i]++;
            if (!(s_axis_tvalid[i] && !hs_src[i]))
                s_axis_tvalid[i] = ($urandom_range(99) < 32'(p_src));
            s_axis_tdata[i*DW +: DW] = src_word(i, src_seq[i]);
            s_axis_tkeep[i*KW +: KW] = src_keep(i, src_seq[i]);
            s_axis_tlast[i]          = 1'(src_seq[i] & 1);
        end
        if (hs_mux && mux_valid) begin
            ent_q.delete(0);
            mux_valid = 1'b0;
        end
        if (!mux_valid && ent_q.size() > 0) begin
            mux_valid = 1'b1;
            mux_data  = ent_q[0];
        end
        m_axis_tready = ($urandom_range(99) < 32'(p_rdy));
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(posedge aclk);
            #2;
            n++;
        end while (!(ent_q.size() == 0 && !mux_valid && bq.size() == 0) && n < 20000);
        if (n >= 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy expected drained", name);
        end
        repeat (2) @(posedge aclk);
        #2;
    endtask

    task automatic start_case(input int ps, input int pr);
        p_src = ps;
        p_rdy = pr;
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
        tr_seen = '0;
    endtask

    initial begin
        int n;
        aresetn = 1'b0;
        mux_valid = 1'b0;
        mux_data = '0;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b0;
        hs_mux = 1'b0;
        hs_src = '0;
        m_err = 1'b0;
        cyc = 0;
        n_cmp = 0;
        n_bad = 0;
        p_src = 100;
        p_rdy = 100;
        for (int i = 0; i < ND; i++) begin
            src_seq[i] = 0;
            exp_seq[i] = 0;
        end

        repeat (3) @(posedge aclk);
        #3;
        chk("rst_mux_ready", 64'(mux_ready), 64'(0));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_err_dest", 64'(err_dest), 64'(0));
        aresetn = 1'b1;
        #1;
        chk("post_rst_mux_ready", 64'(mux_ready), 64'(1));

        // Single 4-beat packet from source 2
        start_case(100, 100);
        ent_q.push_back(mk(2, 3, 6'h11));
        wait_done("t1");
        chk("t1_nbeats", 64'(cap_data.size()), 64'(4));
        for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
            chk("t1_data", 64'(cap_data[k]), 64'(32'h025A_0000 + 32'(k)));
            chk("t1_last", 64'(cap_last[k]), 64'(k == 3));
        end
        chk("t1_other_tready", 64'(tr_seen & 4'b1011), 64'(0));

        // Back-to-back packets with no bubble
        start_case(100, 100);
        ent_q.push_back(mk(0, 0, 6'h22));
        ent_q.push_back(mk(3, 1, 6'h23));
        wait_done("t2");
        chk("t2_nbeats", 64'(cap_data.size()), 64'(3));
        if (cap_data.size() == 3) begin
            chk("t2_d0", 64'(cap_data[0]), 64'(32'h005A_0000));
            chk("t2_d3a", 64'(cap_data[1]), 64'(32'h035A_0000));
            chk("t2_d3b", 64'(cap_data[2]), 64'(32'h035A_0001));
            chk("t2_last", 64'({cap_last[0], cap_last[1], cap_last[2]}), 64'(3'b101));
            chk("t2_gap01", 64'(cap_cyc[1] - cap_cyc[0]), 64'(1));
            chk("t2_gap12", 64'(cap_cyc[2] - cap_cyc[1]), 64'(1));
        end

        // Sink stalls at 50% duty on an 8-beat packet
        start_case(100, 50);
        ent_q.push_back(mk(1, 7, 6'h2A));
        wait_done("t3");
        chk("t3_nbeats", 64'(cap_data.size()), 64'(8));
        for (int k = 0; k < 8 && k < cap_data.size(); k++) begin
            chk("t3_data", 64'(cap_data[k]), 64'(32'h015A_0000 + 32'(k)));
            chk("t3_last", 64'(cap_last[k]), 64'(k == 7));
        end

        // Source tlast on odd sequence numbers (beat 2 and 4) does not end the packet
        start_case(100, 100);
        ent_q.push_back(mk(1, 4, 6'h05));
        wait_done("t4");
        chk("t4_nbeats", 64'(cap_data.size()), 64'(5));
        for (int k = 0; k < 5 && k < cap_data.size(); k++) begin
            chk("t4_data", 64'(cap_data[k]), 64'(32'h015A_0008 + 32'(k)));
            chk("t4_last", 64'(cap_last[k]), 64'(k == 4));
        end

        // Out-of-range dest is consumed and flagged, next entry routes normally
        start_case(100, 100);
        ent_q.push_back(mk(5, 2, 6'h07));
        ent_q.push_back(mk(0, 0, 6'h08));
        wait_done("t5");
        chk("t5_err", 64'(err_dest), 64'(1));
        chk("t5_nbeats", 64'(cap_data.size()), 64'(1));
        if (cap_data.size() == 1) begin
            chk("t5_data", 64'(cap_data[0]), 64'(32'h005A_0001));
            chk("t5_last", 64'(cap_last[0]), 64'(1));
        end
        repeat (5) @(posedge aclk);
        #2;
        chk("t5_err_sticky", 64'(err_dest), 64'(1));

        // Asynchronous reset after beat 2 of a 6-beat packet
        start_case(100, 100);
        ent_q.push_back(mk(2, 5, 6'h3C));
        n = 0;
        while (cap_data.size() < 2 && n < 100) begin
            @(posedge aclk);
            #2;
            n++;
        end
        chk("t6_reached_beat2", 64'(cap_data.size()), 64'(2));
        #1;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_rst_mux_ready", 64'(mux_ready), 64'(0));
        chk("t6_rst_s_tready", 64'(s_axis_tready), 64'(0));
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        chk("t6_post_mux_ready", 64'(mux_ready), 64'(1));
        chk("t6_post_err", 64'(err_dest), 64'(0));
        chk("t6_post_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        wait_done("t6");
        chk("t6_no_replay", 64'(cap_data.size()), 64'(2));

        // Random traffic including out-of-range dests and max len
        start_case(75, 60);
        for (int e = 0; e < 200; e++) begin
            if ($urandom_range(7) == 0)
                ent_q.push_back(mk(int'($urandom_range(15, 4)), int'($urandom_range(15)), int'($urandom_range(63))));
            else
                ent_q.push_back(mk(int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(63))));
        end
        ent_q.push_back(mk(3, 15, 6'h3F));
        wait_done("rand");
        chk("rand_drained", 64'(bq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dest_data_mux.md
Name: dest_data_mux

Overview:
- Data-path companion to the destination request arbiter.
- Consumes the arbiter's multiplexing sequence entries (pid, len, dest), one per granted request.
- Routes exactly len+1 beats from the selected per-destination AXI4-Stream source onto one shared output stream.
- Regenerates tlast from the beat count, so output framing always matches the arbitrated request order.

Parameters:
- DATA_BITS, AXI_DATA_BITS: stream data width; keep width is DATA_BITS/8.
- N_DESTS, 1: number of source streams; must match the arbiter instance.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- mux_valid  in  1  sequence entry valid.
- mux_ready  out  1  sequence entry accept.
- mux_data  in  $bits(mux_user_t)  sequence entry {pid, len, dest}; len = beats-1.
- s_axis_tvalid  in  N_DESTS  per-source valid.
- s_axis_tready  out  N_DESTS  per-source ready.
- s_axis_tdata  in  N_DESTS*DATA_BITS  per-source data, source i at slice i.
- s_axis_tkeep  in  N_DESTS*DATA_BITS/8  per-source keep.
- s_axis_tlast  in  N_DESTS  per-source last; ignored for framing.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  DATA_BITS  output data.
- m_axis_tkeep  out  DATA_BITS/8  output keep.
- m_axis_tlast  out  1  generated last.
- err_dest  out  1  sticky flag: out-of-range dest seen.

Behaviour:
- Reset: aresetn is asynchronous and active-low. Reset forces state IDLE, cnt=0, sel=0, err_dest=0.
  - While in reset: mux_ready=0, all s_axis_tready=0, m_axis_tvalid=0.
  - Reset mid-packet abandons the packet; nothing is replayed.
- States: IDLE, ACTIVE.
- IDLE:
  - mux_ready=1.
  - On mux_valid&mux_ready: latch sel=dest, cnt=len (BLEN_BITS wide), pid.
  - If dest<N_DESTS, go to ACTIVE.
  - Else set err_dest, consume the entry and stay IDLE; no data is routed.
- ACTIVE data path is combinational from source sel:
  - m_axis_tvalid = s_axis_tvalid[sel].
  - s_axis_tready[sel] = m_axis_tready; all other s_axis_tready=0.
  - tdata and tkeep are passed through from source sel.
  - m_axis_tlast = (cnt==0).
- Beat accepted (m_axis_tvalid&m_axis_tready):
  - If cnt!=0, decrement cnt.
  - If cnt==0 (last beat), the packet ends.
- End of packet, same cycle as the last beat:
  - mux_ready=1 (back-to-back pop).
  - If mux_valid with a valid dest: reload sel, cnt, pid and stay ACTIVE, giving zero bubble between packets.
  - If mux_valid with an invalid dest: set err_dest and go to IDLE.
  - If no mux_valid: go to IDLE.
- mux_ready=0 in ACTIVE except on the last-beat handshake cycle.
- Latency:
  - The first beat of a packet is routable the cycle after its entry is accepted from IDLE.
  - For back-to-back packets, the next packet's first beat follows the previous last beat in the next cycle.
- Combinational paths: no combinational path from m_axis_tready to mux_ready except the last-beat term. No combinational path from mux_valid to any output.
- Source tlast does not affect framing. A source asserting tlast early or late still yields exactly len+1 output beats.
- len=0: single-beat packet with tlast on beat 0.
- Maximum len (all ones): cnt counts down without wrap.
- N_DESTS=1: sel is 1 bit wide and constant 0; dest=1 is treated as out of range.
- Output stalls (m_axis_tready=0) hold cnt and sel. The source must keep data stable per AXI4-Stream rules.

Optional Feature:
- Macro DEST_MUX_PID_TUSER_EN.
- Defined: adds output port m_axis_tid (PID_BITS) carrying the latched pid, stable for every beat of the packet and valid whenever m_axis_tvalid=1. Reset value 0.
- Undefined: the port is absent, the pid field of mux_data is discarded, and no pid register is synthesized.

Decomposition:
- lynxTypes supplies:
  - the struct mux_user_t {pid, len, dest}, shared with the arbiter;
  - the constants BLEN_BITS, PID_BITS and AXI_DATA_BITS.
  - Add the localparam DEST_MUX_ERR_* nothing else; the sticky error is a plain flop.
- Natural sub-module: dest_beat_cnt, the loadable down-counter with last flag (load, dec, cnt_zero).
- Output is direct, with no internal skid buffer. Callers add a stream register slice if timing requires it.

Test Plan:
- N_DESTS=4, entry {dest=2, len=3}, source 2 streams 4 beats -> 4 output beats equal to source 2 data, tlast only on beat 4, s_axis_tready[0,1,3] never 1.
- Entries {dest=0, len=0} and {dest=3, len=1} queued, all sources valid -> beats D0, D3a, D3b on consecutive cycles with no bubble, tlast on D0 and D3b.
- Random m_axis_tready toggling at 50% duty during {dest=1, len=7} -> exactly 8 beats, data order preserved, cnt held during stalls.
- Source 1 asserts tlast on beat 2 of {dest=1, len=4} -> still 5 output beats, m_axis_tlast only on beat 5.
- Entry {dest=5} with N_DESTS=4 -> entry consumed, err_dest=1 and stays 1, no output beat; the following {dest=0, len=0} routes normally.
- aresetn low mid-packet (beat 2 of 6) -> outputs go low immediately without waiting for a clock edge. After release: state IDLE, mux_ready=1, err_dest=0. With DEST_MUX_PID_TUSER_EN defined, m_axis_tid equals the entry pid on every beat.
